decode_stage_p: RTL and testbench
=================================

# decode_stage_p

Parametrised decode stage with integrated register file and ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It reads two operands with write-before-read bypass and builds the immediate, and it owns the load-use hazard check. It launches a registered ID/EX bundle of width-generic data, a generic control vector, and an explicit valid bit, honouring downstream hold and flush.

## Interface
- DATA_W, 16: datapath, PC and immediate width; must be >= 16.
- CTRL_W, 15: width of the pass-through control vector.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- valid_id  in  1  IF/ID holds a real instruction.
- instr_id  in  16  instruction; rs = [10:8], rt = [7:5].
- pc_id, pc2_id  in  DATA_W  PC and PC+2 of the instruction.
- regdst  in  2  write-address select.
- rs_used, rt_used  in  1  instruction actually reads rs/rt (hazard qualification).
- regwrite, memread  in  1  instruction writes a register / is a load.
- imm_mode  in  3  {zero_ex, size[1:0]}.
- ctrl_id  in  CTRL_W  remaining decoded control.
- wb_en  in  1  writeback enable.
- wb_addr  in  3  writeback register.
- wb_data  in  DATA_W  writeback data.
- hold  in  1  downstream stall; ID/EX keeps its contents.
- flush  in  1  kill the instruction in decode.
- stall_out  out  1  IF/PC must hold this cycle.
- valid_ex, regwrite_ex, memread_ex  out  1  registered valid and side-effect controls.
- ctrl_ex  out  CTRL_W  registered control vector.
- pc_ex, pc2_ex, rd1_ex, rd2_ex, imm_ex  out  DATA_W  registered data.
- rt_addr_ex, wr_addr_ex  out  3  registered rt and destination addresses.
- err  out  1  sticky error flag.

## Operation
- **Register file:** 8 x DATA_W. R0 is a general register.
  - Write occurs on a rising edge when wb_en = 1, independent of hold/flush.
  - Read is combinational. If wb_en and wb_addr equals the read address, the port returns wb_data (bypass).
- **Write address:**
  - regdst 00 -> instr[7:5]
  - regdst 01 -> instr[4:2]
  - regdst 10 -> instr[10:8]
  - regdst 11 -> 3'd7
- **Immediate:** size 00 -> instr[4:0], 01 -> [7:0], 10 -> [10:0]. Result is sign-extended (zero_ex = 0) or zero-extended (zero_ex = 1) to DATA_W. size 11 is reserved: imm = 0.
- **Hazard:**
  - hazard = valid_id & valid_ex & memread_ex & regwrite_ex & ((rs_used & wr_addr_ex == rs) | (rt_used & wr_addr_ex == rt)).
  - stall_out = hold | (hazard & ~flush).
- **ID/EX update priority per edge:** reset > hold > flush > hazard > normal.
  - hold: every ID/EX output keeps its value.
  - flush or hazard (bubble): valid_ex, regwrite_ex, memread_ex = 0 and ctrl_ex = 0. Data/address fields load normally and are don't-care.
  - normal: all fields load. valid_ex = valid_id. regwrite_ex, memread_ex and ctrl_ex are gated to 0 when valid_id = 0.
- **err:** set on an edge where valid_id & ~flush & ~hold & imm_mode[1:0] == 11. Cleared only by reset.

## Timing
- rst low: all registers, including all 8 file entries, ID/EX fields and err, go to 0 immediately (asynchronous).
- stall_out is combinational from current inputs and ID/EX state. With rst low, valid_ex = 0, so stall_out = hold.
- Latency is one cycle, IF/ID to ID/EX.
- Writeback data presented in cycle N is visible on rd1/rd2 in the same cycle through the bypass, and captured in rd*_ex at the end of cycle N.
- A load-use pair costs exactly one bubble. After the bubble, valid_ex = 0, so hazard deasserts with no extra stall.
- Hold with hazard present: stall_out = 1 and ID/EX is frozen. The hazard persists until hold drops, then one bubble is inserted.
- Flush with hazard: flush wins, giving one bubble with stall_out = hold.
- Reset deasserting mid-stream: the first edge after release loads normally.

## Test plan
- **Reset, then bypass:** reset, then write R3 = 0x1234 with wb_en while instr reads rs = 3 -> rd1_ex = 0x1234 the next cycle. All regs read 0 immediately after reset.
- **Immediate:** instr[4:0] = 5'b10000 with imm_mode 000 -> imm_ex = 0xFFF0. With mode 100 -> 0x0010. Mode 011 -> imm_ex = 0 and err = 1, err remaining 1 until rst.
- **Load-use:** load to R2 in ID/EX, next instr rs = 2 with rs_used -> stall_out = 1 for one cycle, bubble (valid_ex = 0, ctrl_ex = 0), then the instruction issues with valid_ex = 1.
- **rt_used = 0 case:** the same load with rt = 2 and rt_used = 0 -> no stall.
- **Hold:** assert hold for 3 cycles -> ID/EX outputs are unchanged and stall_out = 1 throughout. A concurrent writeback still updates the file.
- **Flush during hazard:** flush with a hazard present -> stall_out = 0 and one bubble. With DATA_W = 32, a PC of 0x0001_0000 propagates intact to pc_ex.

Source files
------------

// File: rtl/decode_stage_p.sv
// Decode stage: 8-entry register file with write-before-read bypass, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_p #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_id,
    input  logic [15:0]       instr_id,
    input  logic [DATA_W-1:0] pc_id,
    input  logic [DATA_W-1:0] pc2_id,
    input  logic [1:0]        regdst,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              regwrite,
    input  logic              memread,
    input  logic [2:0]        imm_mode,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              hold,
    input  logic              flush,
    output logic              stall_out,
    output logic              valid_ex,
    output logic              regwrite_ex,
    output logic              memread_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [DATA_W-1:0] pc_ex,
    output logic [DATA_W-1:0] pc2_ex,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [2:0]        rt_addr_ex,
    output logic [2:0]        wr_addr_ex,
    output logic              err
);

    localparam int unsigned NREGS = 8;

    logic [DATA_W-1:0] rf [NREGS];
    logic [2:0]        rs_c;
    logic [2:0]        rt_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic [2:0]        wr_addr_c;
    logic [DATA_W-1:0] imm_c;
    logic              hazard_c;
    logic              bubble_c;
    logic              imm_bad_c;
    logic              unused_instr_bits;

    assign rs_c = instr_id[10:8];
    assign rt_c = instr_id[7:5];
    assign unused_instr_bits = ^instr_id[15:11];

    // Register file: writeback happens regardless of hold/flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Read ports with same-cycle writeback bypass
    always_comb begin
        rd1_c = rf[rs_c];
        rd2_c = rf[rt_c];
        if (wb_en && (wb_addr == rs_c)) rd1_c = wb_data;
        if (wb_en && (wb_addr == rt_c)) rd2_c = wb_data;
    end

    always_comb begin
        wr_addr_c = instr_id[7:5];
        case (regdst)
            2'b00:   wr_addr_c = instr_id[7:5];
            2'b01:   wr_addr_c = instr_id[4:2];
            2'b10:   wr_addr_c = instr_id[10:8];
            default: wr_addr_c = 3'd7;
        endcase
    end

    // Immediate: imm_mode[2] selects zero extension, [1:0] the field size
    always_comb begin
        imm_c = '0;
        case (imm_mode[1:0])
            2'b00:   imm_c = {{(DATA_W-5){instr_id[4] & ~imm_mode[2]}}, instr_id[4:0]};
            2'b01:   imm_c = {{(DATA_W-8){instr_id[7] & ~imm_mode[2]}}, instr_id[7:0]};
            2'b10:   imm_c = {{(DATA_W-11){instr_id[10] & ~imm_mode[2]}}, instr_id[10:0]};
            default: imm_c = '0;
        endcase
    end

    assign hazard_c  = valid_id & valid_ex & memread_ex & regwrite_ex &
                       ((rs_used & (wr_addr_ex == rs_c)) | (rt_used & (wr_addr_ex == rt_c)));
    assign stall_out = hold | (hazard_c & ~flush);
    assign bubble_c  = flush | hazard_c;
    assign imm_bad_c = valid_id & ~flush & ~hold & (imm_mode[1:0] == 2'b11);

    // ID/EX register: hold freezes everything, a bubble clears only the controls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_ex    <= 1'b0;
            regwrite_ex <= 1'b0;
            memread_ex  <= 1'b0;
            ctrl_ex     <= '0;
            pc_ex       <= '0;
            pc2_ex      <= '0;
            rd1_ex      <= '0;
            rd2_ex      <= '0;
            imm_ex      <= '0;
            rt_addr_ex  <= '0;
            wr_addr_ex  <= '0;
        end else if (!hold) begin
            pc_ex      <= pc_id;
            pc2_ex     <= pc2_id;
            rd1_ex     <= rd1_c;
            rd2_ex     <= rd2_c;
            imm_ex     <= imm_c;
            rt_addr_ex <= rt_c;
            wr_addr_ex <= wr_addr_c;
            if (bubble_c) begin
                valid_ex    <= 1'b0;
                regwrite_ex <= 1'b0;
                memread_ex  <= 1'b0;
                ctrl_ex     <= '0;
            end else begin
                valid_ex    <= valid_id;
                regwrite_ex <= valid_id & regwrite;
                memread_ex  <= valid_id & memread;
                ctrl_ex     <= valid_id ? ctrl_id : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           err <= 1'b0;
        else if (imm_bad_c) err <= 1'b1;
    end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p at DATA_W = 32 with immediate assertions.
module tb_decode_stage_p;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_id;
    logic [15:0]   instr_id;
    logic [DW-1:0] pc_id, pc2_id;
    logic [1:0]    regdst;
    logic          rs_used, rt_used, regwrite, memread;
    logic [2:0]    imm_mode;
    logic [CW-1:0] ctrl_id;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          hold, flush;
    logic          stall_out, valid_ex, regwrite_ex, memread_ex, err;
    logic [CW-1:0] ctrl_ex;
    logic [DW-1:0] pc_ex, pc2_ex, rd1_ex, rd2_ex, imm_ex;
    logic [2:0]    rt_addr_ex, wr_addr_ex;

    int total = 0;
    int bad   = 0;

    decode_stage_p #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_id(valid_id), .instr_id(instr_id),
        .pc_id(pc_id), .pc2_id(pc2_id), .regdst(regdst), .rs_used(rs_used),
        .rt_used(rt_used), .regwrite(regwrite), .memread(memread),
        .imm_mode(imm_mode), .ctrl_id(ctrl_id), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .hold(hold), .flush(flush), .stall_out(stall_out),
        .valid_ex(valid_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
        .ctrl_ex(ctrl_ex), .pc_ex(pc_ex), .pc2_ex(pc2_ex), .rd1_ex(rd1_ex),
        .rd2_ex(rd2_ex), .imm_ex(imm_ex), .rt_addr_ex(rt_addr_ex),
        .wr_addr_ex(wr_addr_ex), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [4:0] lo);
        return {5'b0, rs, rt, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; valid_id = 1'b0; instr_id = '0; pc_id = '0; pc2_id = '0;
        regdst = 2'b00; rs_used = 1'b0; rt_used = 1'b0; regwrite = 1'b0;
        memread = 1'b0; imm_mode = 3'b000; ctrl_id = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; hold = 1'b0; flush = 1'b0;

        // Reset state
        #2;
        check("rst_valid", valid_ex, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_stall", stall_out, 1'b0);
        hold = 1'b1;
        #1;
        check("rst_stall_hold", stall_out, 1'b1);
        hold = 1'b0;
        tick();

        // First instruction after reset: all registers read 0
        rst = 1'b1;
        valid_id = 1'b1; instr_id = mk(3'd5, 3'd6, 5'd0); regdst = 2'b00;
        regwrite = 1'b1; ctrl_id = 15'h1234; pc_id = 32'h0001_0000; pc2_id = 32'h0001_0002;
        tick();
        check("first_valid", valid_ex, 1'b1);
        check("first_rd1", rd1_ex, 32'h0);
        check("first_rd2", rd2_ex, 32'h0);
        check("first_wr", wr_addr_ex, 3'd6);
        check("first_rt", rt_addr_ex, 3'd6);
        check("first_ctrl", ctrl_ex, 15'h1234);
        check("first_pc", pc_ex, 32'h0001_0000);
        check("first_pc2", pc2_ex, 32'h0001_0002);
        check("first_rw", regwrite_ex, 1'b1);

        // Bypass R3 = 0x1234, sign-extended 5-bit immediate, regdst 01
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'h1234;
        instr_id = mk(3'd3, 3'd0, 5'b10000); regdst = 2'b01; imm_mode = 3'b000;
        tick();
        check("byp_rd1", rd1_ex, 32'h1234);
        check("byp_rd2", rd2_ex, 32'h0);
        check("imm5_sx", imm_ex, 32'hFFFF_FFF0);
        check("wr_rd01", wr_addr_ex, 3'd4);

        // Stored value, zero-extended 5-bit immediate, regdst 10
        wb_en = 1'b0;
        imm_mode = 3'b100; regdst = 2'b10;
        tick();
        check("rf_rd1", rd1_ex, 32'h1234);
        check("imm5_zx", imm_ex, 32'h0000_0010);
        check("wr_rd10", wr_addr_ex, 3'd3);

        // 8-bit sign extension, regdst 11
        instr_id = mk(3'd3, 3'b111, 5'b00001); imm_mode = 3'b001; regdst = 2'b11;
        tick();
        check("imm8_sx", imm_ex, 32'hFFFF_FFE1);
        check("wr_rd11", wr_addr_ex, 3'd7);

        // 11-bit sign and zero extension
        instr_id = mk(3'd4, 3'd0, 5'd0); imm_mode = 3'b010; regdst = 2'b00;
        tick();
        check("imm11_sx", imm_ex, 32'hFFFF_FC00);
        imm_mode = 3'b110;
        tick();
        check("imm11_zx", imm_ex, 32'h0000_0400);
        check("err_clean", err, 1'b0);

        // Load-use on rs: one stall, one bubble, then issue
        imm_mode = 3'b000;
        instr_id = mk(3'd1, 3'd2, 5'd0); memread = 1'b1; regwrite = 1'b1; ctrl_id = 15'h00AA;
        tick();
        check("ld_memread", memread_ex, 1'b1);
        check("ld_wr", wr_addr_ex, 3'd2);
        instr_id = mk(3'd2, 3'd0, 5'd0); memread = 1'b0; rs_used = 1'b1; rt_used = 1'b1;
        ctrl_id = 15'h0155;
        #1;
        check("lu_stall", stall_out, 1'b1);
        tick();
        check("lu_bub_valid", valid_ex, 1'b0);
        check("lu_bub_ctrl", ctrl_ex, 15'h0);
        check("lu_bub_rw", regwrite_ex, 1'b0);
        check("lu_stall_after", stall_out, 1'b0);
        tick();
        check("lu_issue_valid", valid_ex, 1'b1);
        check("lu_issue_ctrl", ctrl_ex, 15'h0155);

        // Load followed by rt match with rt_used = 0: no stall
        instr_id = mk(3'd1, 3'd2, 5'd0); memread = 1'b1; rs_used = 1'b0; rt_used = 1'b0;
        tick();
        instr_id = mk(3'd0, 3'd2, 5'd0); memread = 1'b0; rs_used = 1'b1; rt_used = 1'b0;
        ctrl_id = 15'h00F0; pc_id = 32'h0000_3000;
        #1;
        check("rtu0_stall", stall_out, 1'b0);
        tick();
        check("rtu0_valid", valid_ex, 1'b1);
        check("rtu0_ctrl", ctrl_ex, 15'h00F0);

        // Hold for 3 cycles with concurrent writeback to R5
        hold = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 32'hBEEF;
        ctrl_id = 15'h07FF; pc_id = 32'h0000_2000; instr_id = mk(3'd5, 3'd5, 5'd0);
        rs_used = 1'b0;
        #1;
        check("hold_stall0", stall_out, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", valid_ex, 1'b1);
            check("hold_ctrl", ctrl_ex, 15'h00F0);
            check("hold_pc", pc_ex, 32'h0000_3000);
            check("hold_stall", stall_out, 1'b1);
        end
        hold = 1'b0; wb_en = 1'b0; regwrite = 1'b0;
        tick();
        check("hold_wb_rd1", rd1_ex, 32'hBEEF);
        check("hold_rel_ctrl", ctrl_ex, 15'h07FF);
        check("hold_rel_rw", regwrite_ex, 1'b0);

        // Flush wins over a load-use hazard; wide PC survives
        instr_id = mk(3'd0, 3'd4, 5'd0); memread = 1'b1; regwrite = 1'b1;
        pc_id = 32'h0001_0000;
        tick();
        instr_id = mk(3'd4, 3'd0, 5'd0); memread = 1'b0; rs_used = 1'b1; ctrl_id = 15'h0003;
        flush = 1'b1;
        #1;
        check("fl_stall", stall_out, 1'b0);
        tick();
        check("fl_valid", valid_ex, 1'b0);
        check("fl_ctrl", ctrl_ex, 15'h0);
        flush = 1'b0;
        #1;
        check("fl_stall_after", stall_out, 1'b0);
        tick();
        check("fl_issue_valid", valid_ex, 1'b1);
        check("fl_pc", pc_ex, 32'h0001_0000);

        // Reserved immediate size: imm = 0 and sticky err
        rs_used = 1'b0; imm_mode = 3'b011; instr_id = mk(3'd3, 3'd0, 5'b11111);
        tick();
        check("res_imm", imm_ex, 32'h0);
        check("res_err", err, 1'b1);
        imm_mode = 3'b000;
        tick();
        check("err_sticky", err, 1'b1);

        // Asynchronous reset mid-stream clears everything, including the file
        #2;
        rst = 1'b0;
        #1;
        check("ar_err", err, 1'b0);
        check("ar_valid", valid_ex, 1'b0);
        check("ar_stall", stall_out, 1'b0);
        #1;
        rst = 1'b1;
        instr_id = mk(3'd3, 3'd5, 5'd0); ctrl_id = 15'h0042;
        tick();
        check("ar_first_valid", valid_ex, 1'b1);
        check("ar_rf_r3", rd1_ex, 32'h0);
        check("ar_rf_r5", rd2_ex, 32'h0);
        check("ar_first_ctrl", ctrl_ex, 15'h0042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
